pwm_phase_ctrl: RTL and testbench
=================================

Name: pwm_phase_ctrl

Overview:
Run-time controller for the interleaved PWM phase block. It owns the four carrier/compare words fed to every interleave (Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount) and the global PWM enable. It accepts new configuration over a valid/ready handshake and applies it only at carrier period boundaries. It sequences start-up with a soft-start ramp on Compare, and latches faults into a safe shutdown state.

Parameters:
RampStep, 16, Compare increment per carrier period during soft-start
DefaultMaxCount, 1000, PWMMaxCount after reset
DefaultStepSize, 1, TriangleStepSize after reset
DefaultDeadTime, 10, DeadTimeCount after reset

Ports:
MClk  in  1  system clock
Rst  in  1  synchronous reset, active-high
Start  in  1  level; 1 = run PWM, 0 = stop
FaultIn  in  1  level; external fault, highest priority
FaultClear  in  1  single-cycle pulse; clears a latched fault
PeriodSync  in  1  single-cycle pulse at carrier period start (counter = 0)
CfgValid  in  1  configuration write request
CfgReady  out  1  controller can accept configuration
CfgCompare  in  16  requested duty compare
CfgMaxCount  in  16  requested carrier max count
CfgStepSize  in  16  requested triangle step
CfgDeadTime  in  16  requested dead time
Compare  out  16  to phase block
PWMMaxCount  out  16  to phase block
TriangleStepSize  out  16  to phase block
DeadTimeCount  out  16  to phase block
PwmEnable  out  1  gates all switch outputs
State  out  2  0 IDLE, 1 SOFTSTART, 2 RUN, 3 FAULT
FaultLatched  out  1  sticky fault flag

Behaviour:
- One clock (MClk). Reset is synchronous and active-high (Rst). All outputs are registered.
- Reset values:
  - State = IDLE, Compare = 0, PwmEnable = 0, FaultLatched = 0, CfgReady = 1.
  - PWMMaxCount, TriangleStepSize and DeadTimeCount take their Default* values.
  - Shadow registers take the same defaults, with shadow compare = 0.
  - Pending = 0, StopReq = 0.
- Rst overrides everything, including mid-ramp and FAULT.
- Config handshake:
  - Transfer occurs on CfgValid & CfgReady. It captures all four Cfg* words into the shadow registers and sets Pending.
  - CfgReady = !Pending. It goes low the cycle after the transfer.
  - Shadow compare = min(CfgCompare, CfgMaxCount).
- Config apply:
  - Pending shadow is copied to PWMMaxCount, TriangleStepSize and DeadTimeCount, and the compare target Target is updated.
  - In IDLE/FAULT the apply happens the cycle after capture. In SOFTSTART/RUN it happens only on PeriodSync.
  - Pending clears on apply, so CfgReady returns to 1 on the following cycle.
  - The Compare output follows the state rules below, not the apply.
- FSM, evaluated in priority order every cycle:
  - Any state with FaultIn = 1 → FAULT next cycle. PwmEnable = 0, Compare = 0, FaultLatched = 1. This beats Start, PeriodSync and the apply.
  - IDLE: PwmEnable = 0, Compare = 0. If Start = 1 and FaultLatched = 0, go to SOFTSTART and set PwmEnable = 1 next cycle.
  - SOFTSTART: on each PeriodSync, Compare <= min(Compare + RampStep, Target).
    - The sum is computed 17-bit, so it cannot wrap.
    - If the new Compare equals Target, go to RUN.
    - If Target is 0, go to RUN on the first PeriodSync.
    - If Target decreases below Compare, Compare drops to Target and the state goes to RUN.
  - RUN: on PeriodSync, Compare <= Target, so a new config and its new compare land on the same boundary.
  - Start = 0 in SOFTSTART/RUN sets StopReq. On the next PeriodSync, go to IDLE with PwmEnable = 0 and Compare = 0. The current period finishes cleanly.
    - If Start returns to 1 before that PeriodSync, StopReq clears and the state stays where it is.
  - FAULT: hold the safe outputs. Exit to IDLE only when FaultClear = 1, FaultIn = 0 and Start = 0; FaultLatched clears on that exit. FaultClear is ignored otherwise.
- FaultLatched is a pure sticky flag. Config transfers remain legal in every state.

Test Plan:
- Reset: hold Rst for 2 cycles → State = 0, Compare = 0, PWMMaxCount = 1000, TriangleStepSize = 1, DeadTimeCount = 10, PwmEnable = 0, CfgReady = 1.
- Soft-start ramp:
  - Stimulus: config Cmp = 50, Max = 1000 in IDLE; raise Start; issue PeriodSync every 20 cycles.
  - Response: Compare goes 16, 32, 48, 50 on successive syncs; State = RUN after the 4th sync; PwmEnable = 1 from the cycle after Start.
- Boundary apply:
  - Stimulus: in RUN, write Cmp = 700, Max = 500.
  - Response: CfgReady = 0 and outputs unchanged until PeriodSync; the cycle after sync, PWMMaxCount = 500 and Compare = 500 (clamped); CfgReady = 1 one cycle later.
- Fault:
  - Stimulus: in SOFTSTART, raise FaultIn in the same cycle as PeriodSync.
  - Response: next cycle State = 3, Compare = 0, PwmEnable = 0, FaultLatched = 1.
  - FaultClear with Start = 1 → remains FAULT. FaultClear with Start = 0 and FaultIn = 0 → IDLE, FaultLatched = 0.
- Stop:
  - Stimulus: in RUN, drop Start 5 cycles before PeriodSync.
  - Response: PwmEnable stays 1 until the cycle after sync, then IDLE with Compare = 0.
  - Re-raising Start before the sync cancels the stop.
- Reset mid-ramp: assert Rst during SOFTSTART at Compare = 32 → all reset values next cycle, including the applied config words.

Source files
------------

// File: rtl/pwm_phase_ctrl.sv
// Run-time controller for the interleaved PWM phase block: shadowed carrier/compare
// configuration applied on period boundaries, soft-start ramp, stop sequencing and fault latch.
module pwm_phase_ctrl #(
    parameter int unsigned RampStep        = 16,
    parameter int unsigned DefaultMaxCount = 1000,
    parameter int unsigned DefaultStepSize = 1,
    parameter int unsigned DefaultDeadTime = 10
) (
    input  logic        MClk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        FaultIn,
    input  logic        FaultClear,
    input  logic        PeriodSync,
    input  logic        CfgValid,
    output logic        CfgReady,
    input  logic [15:0] CfgCompare,
    input  logic [15:0] CfgMaxCount,
    input  logic [15:0] CfgStepSize,
    input  logic [15:0] CfgDeadTime,
    output logic [15:0] Compare,
    output logic [15:0] PWMMaxCount,
    output logic [15:0] TriangleStepSize,
    output logic [15:0] DeadTimeCount,
    output logic        PwmEnable,
    output logic [1:0]  State,
    output logic        FaultLatched
);

    typedef enum logic [1:0] {
        Idle      = 2'd0,
        SoftStart = 2'd1,
        Run       = 2'd2,
        Fault     = 2'd3
    } stateT;

    stateT       stateReg;
    logic [15:0] shadowCompareReg;
    logic [15:0] shadowMaxCountReg;
    logic [15:0] shadowStepSizeReg;
    logic [15:0] shadowDeadTimeReg;
    logic [15:0] targetReg;
    logic        pendingReg;
    logic        stopReqReg;

    logic        cfgXfer;
    logic [15:0] shadowCompareIn;
    logic        atBoundary;
    logic        applyNow;
    logic [15:0] effTarget;
    logic [16:0] rampSum;
    logic        rampDone;
    logic [15:0] rampNext;
    logic        stopNow;

    assign State           = stateReg;
    assign cfgXfer         = CfgValid & CfgReady;
    assign shadowCompareIn = (CfgCompare > CfgMaxCount) ? CfgMaxCount : CfgCompare;

    // While the carrier is stopped there is no period to protect, so apply right away.
    assign atBoundary = ((stateReg == Idle) || (stateReg == Fault)) ? 1'b1 : PeriodSync;
    assign applyNow   = pendingReg & ~FaultIn & atBoundary;
    assign effTarget  = applyNow ? shadowCompareReg : targetReg;

    // 17-bit sum keeps the ramp from wrapping near full scale; min() also covers a target
    // that dropped below the current compare.
    assign rampSum  = {1'b0, Compare} + 17'(RampStep);
    assign rampDone = (rampSum >= {1'b0, effTarget});
    assign rampNext = rampDone ? effTarget : rampSum[15:0];

    // Stop only if Start was already low before this boundary and is still low now.
    assign stopNow = stopReqReg & ~Start;

    always_ff @(posedge MClk) begin
        if (Rst) begin
            stateReg          <= Idle;
            Compare           <= '0;
            PWMMaxCount       <= 16'(DefaultMaxCount);
            TriangleStepSize  <= 16'(DefaultStepSize);
            DeadTimeCount     <= 16'(DefaultDeadTime);
            shadowCompareReg  <= '0;
            shadowMaxCountReg <= 16'(DefaultMaxCount);
            shadowStepSizeReg <= 16'(DefaultStepSize);
            shadowDeadTimeReg <= 16'(DefaultDeadTime);
            targetReg         <= '0;
            pendingReg        <= 1'b0;
            stopReqReg        <= 1'b0;
            PwmEnable         <= 1'b0;
            FaultLatched      <= 1'b0;
            CfgReady          <= 1'b1;
        end else begin
            if (cfgXfer) begin
                shadowCompareReg  <= shadowCompareIn;
                shadowMaxCountReg <= CfgMaxCount;
                shadowStepSizeReg <= CfgStepSize;
                shadowDeadTimeReg <= CfgDeadTime;
                pendingReg        <= 1'b1;
            end else if (applyNow) begin
                PWMMaxCount      <= shadowMaxCountReg;
                TriangleStepSize <= shadowStepSizeReg;
                DeadTimeCount    <= shadowDeadTimeReg;
                targetReg        <= shadowCompareReg;
                pendingReg       <= 1'b0;
            end
            // Ready drops with the transfer and returns one cycle after the apply.
            CfgReady <= cfgXfer ? 1'b0 : ~pendingReg;

            if (FaultIn) begin
                stateReg     <= Fault;
                Compare      <= '0;
                PwmEnable    <= 1'b0;
                FaultLatched <= 1'b1;
                stopReqReg   <= 1'b0;
            end else begin
                case (stateReg)
                    Idle: begin
                        Compare    <= '0;
                        PwmEnable  <= 1'b0;
                        stopReqReg <= 1'b0;
                        if (Start && !FaultLatched) begin
                            stateReg  <= SoftStart;
                            PwmEnable <= 1'b1;
                        end
                    end
                    SoftStart: begin
                        if (PeriodSync && stopNow) begin
                            stateReg   <= Idle;
                            Compare    <= '0;
                            PwmEnable  <= 1'b0;
                            stopReqReg <= 1'b0;
                        end else begin
                            stopReqReg <= ~Start;
                            if (PeriodSync) begin
                                Compare <= rampNext;
                                if (rampDone) begin
                                    stateReg <= Run;
                                end
                            end
                        end
                    end
                    Run: begin
                        if (PeriodSync && stopNow) begin
                            stateReg   <= Idle;
                            Compare    <= '0;
                            PwmEnable  <= 1'b0;
                            stopReqReg <= 1'b0;
                        end else begin
                            stopReqReg <= ~Start;
                            if (PeriodSync) begin
                                Compare <= effTarget;
                            end
                        end
                    end
                    Fault: begin
                        Compare    <= '0;
                        PwmEnable  <= 1'b0;
                        stopReqReg <= 1'b0;
                        if (FaultClear && !Start) begin
                            stateReg     <= Idle;
                            FaultLatched <= 1'b0;
                        end
                    end
                    default: begin
                        stateReg <= Idle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_phase_ctrl.sv
// Directed bench for pwm_phase_ctrl: reset, soft-start ramp, boundary apply, stop/cancel,
// fault latch/clear and reset during the ramp, with hand-computed expectations.
module tb_pwm_phase_ctrl;

    logic        MClk = 1'b0;
    logic        Rst;
    logic        Start;
    logic        FaultIn;
    logic        FaultClear;
    logic        PeriodSync;
    logic        CfgValid;
    logic        CfgReady;
    logic [15:0] CfgCompare;
    logic [15:0] CfgMaxCount;
    logic [15:0] CfgStepSize;
    logic [15:0] CfgDeadTime;
    logic [15:0] Compare;
    logic [15:0] PWMMaxCount;
    logic [15:0] TriangleStepSize;
    logic [15:0] DeadTimeCount;
    logic        PwmEnable;
    logic [1:0]  State;
    logic        FaultLatched;

    int passed = 0;
    int total  = 0;

    pwm_phase_ctrl dut (
        .MClk             (MClk),
        .Rst              (Rst),
        .Start            (Start),
        .FaultIn          (FaultIn),
        .FaultClear       (FaultClear),
        .PeriodSync       (PeriodSync),
        .CfgValid         (CfgValid),
        .CfgReady         (CfgReady),
        .CfgCompare       (CfgCompare),
        .CfgMaxCount      (CfgMaxCount),
        .CfgStepSize      (CfgStepSize),
        .CfgDeadTime      (CfgDeadTime),
        .Compare          (Compare),
        .PWMMaxCount      (PWMMaxCount),
        .TriangleStepSize (TriangleStepSize),
        .DeadTimeCount    (DeadTimeCount),
        .PwmEnable        (PwmEnable),
        .State            (State),
        .FaultLatched     (FaultLatched)
    );

    always #5 MClk = ~MClk;

    task automatic tick(input int n);
        repeat (n) @(posedge MClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic syncPulse();
        PeriodSync = 1'b1;
        tick(1);
        PeriodSync = 1'b0;
    endtask

    task automatic cfgWrite(input logic [15:0] cmp, input logic [15:0] mx,
                            input logic [15:0] st, input logic [15:0] dt);
        CfgCompare  = cmp;
        CfgMaxCount = mx;
        CfgStepSize = st;
        CfgDeadTime = dt;
        CfgValid    = 1'b1;
        tick(1);
        CfgValid    = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; FaultIn = 1'b0; FaultClear = 1'b0; PeriodSync = 1'b0;
        CfgValid = 1'b0; CfgCompare = '0; CfgMaxCount = '0; CfgStepSize = '0; CfgDeadTime = '0;
        tick(2);
        Rst = 1'b0;
        check("rst_state", State, 0);
        check("rst_compare", Compare, 0);
        check("rst_maxcount", PWMMaxCount, 1000);
        check("rst_stepsize", TriangleStepSize, 1);
        check("rst_deadtime", DeadTimeCount, 10);
        check("rst_pwmen", PwmEnable, 0);
        check("rst_cfgready", CfgReady, 1);
        check("rst_faultlatched", FaultLatched, 0);
        $display("step reset done: State=%0d Compare=%0d", State, Compare);

        // Soft-start ramp to 50
        cfgWrite(16'd50, 16'd1000, 16'd1, 16'd10);
        check("idle_cfgready_low", CfgReady, 0);
        tick(2);
        check("idle_cfgready_back", CfgReady, 1);
        Start = 1'b1;
        tick(1);
        check("ss_pwmen", PwmEnable, 1);
        check("ss_state", State, 1);
        check("ss_compare0", Compare, 0);
        tick(19); syncPulse();
        check("ramp1_compare", Compare, 16);
        tick(19); syncPulse();
        check("ramp2_compare", Compare, 32);
        tick(19); syncPulse();
        check("ramp3_compare", Compare, 48);
        check("ramp3_state", State, 1);
        tick(19); syncPulse();
        check("ramp4_compare", Compare, 50);
        check("ramp4_state", State, 2);
        $display("step ramp done: State=%0d Compare=%0d", State, Compare);

        // Boundary apply with compare clamped to max count
        tick(3);
        cfgWrite(16'd700, 16'd500, 16'd2, 16'd20);
        check("ba_cfgready_low", CfgReady, 0);
        tick(3);
        check("ba_hold_compare", Compare, 50);
        check("ba_hold_maxcount", PWMMaxCount, 1000);
        check("ba_hold_cfgready", CfgReady, 0);
        syncPulse();
        check("ba_maxcount", PWMMaxCount, 500);
        check("ba_compare_clamped", Compare, 500);
        check("ba_stepsize", TriangleStepSize, 2);
        check("ba_deadtime", DeadTimeCount, 20);
        check("ba_cfgready_still_low", CfgReady, 0);
        tick(1);
        check("ba_cfgready_back", CfgReady, 1);
        $display("step boundary apply done: Max=%0d Compare=%0d", PWMMaxCount, Compare);

        // Stop: Start drops 5 cycles before sync
        tick(3);
        Start = 1'b0;
        tick(4);
        check("stop_pwmen_hold", PwmEnable, 1);
        check("stop_state_hold", State, 2);
        syncPulse();
        check("stop_state", State, 0);
        check("stop_pwmen", PwmEnable, 0);
        check("stop_compare", Compare, 0);
        $display("step stop done: State=%0d", State);

        // Restart, then cancel a stop request before the sync
        Start = 1'b1;
        tick(1);
        syncPulse();
        check("restart_compare", Compare, 16);
        Start = 1'b0;
        tick(2);
        Start = 1'b1;
        tick(2);
        syncPulse();
        check("cancel_state", State, 1);
        check("cancel_compare", Compare, 32);
        check("cancel_pwmen", PwmEnable, 1);
        $display("step stop-cancel done: State=%0d Compare=%0d", State, Compare);

        // Fault coinciding with a ramp sync
        FaultIn = 1'b1;
        PeriodSync = 1'b1;
        tick(1);
        PeriodSync = 1'b0;
        check("fault_state", State, 3);
        check("fault_compare", Compare, 0);
        check("fault_pwmen", PwmEnable, 0);
        check("fault_latched", FaultLatched, 1);
        FaultIn = 1'b0;
        FaultClear = 1'b1;
        tick(1);
        FaultClear = 1'b0;
        check("fault_clear_start_state", State, 3);
        check("fault_clear_start_latched", FaultLatched, 1);
        Start = 1'b0;
        tick(1);
        FaultClear = 1'b1;
        tick(1);
        FaultClear = 1'b0;
        check("fault_exit_state", State, 0);
        check("fault_exit_latched", FaultLatched, 0);
        $display("step fault done: State=%0d FaultLatched=%0d", State, FaultLatched);

        // Reset in the middle of a ramp
        Start = 1'b1;
        tick(1);
        syncPulse();
        syncPulse();
        check("midramp_compare", Compare, 32);
        Rst = 1'b1;
        tick(1);
        Rst = 1'b0;
        Start = 1'b0;
        check("midrst_state", State, 0);
        check("midrst_compare", Compare, 0);
        check("midrst_maxcount", PWMMaxCount, 1000);
        check("midrst_stepsize", TriangleStepSize, 1);
        check("midrst_deadtime", DeadTimeCount, 10);
        check("midrst_pwmen", PwmEnable, 0);
        check("midrst_cfgready", CfgReady, 1);
        $display("step mid-ramp reset done: State=%0d Compare=%0d", State, Compare);

        // Target zero after reset: first sync goes straight to RUN
        Start = 1'b1;
        tick(1);
        syncPulse();
        check("zero_target_state", State, 2);
        check("zero_target_compare", Compare, 0);
        $display("step zero target done: State=%0d Compare=%0d", State, Compare);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
